// File: rtl/jk_counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_counter_ctrl_pkg
// Description : Shared encodings for the JK counter controller: command modes
//               and sequencer states.
// Revision    : 1.0 - initial release
// ============================================================================
package jk_counter_ctrl_pkg;

    // Command mode encodings (cmd_mode)
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage : jk_counter_ctrl_pkg
`default_nettype wire

// File: rtl/jk_counter_ctrl_cell.sv
`default_nettype none
// ============================================================================
// Module      : jk_cell
// Description : Single JK flip-flop with synchronous active-high reset.
//               Excitation {j,k}: 00 hold, 01 reset, 10 set, 11 toggle.
// Ports       : clk - clock, rising edge
//               rst - synchronous active-high reset (q -> 0)
//               j,k - excitation inputs
//               q   - cell output
// Revision    : 1.0 - initial release
// ============================================================================
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule : jk_cell
`default_nettype wire

// File: rtl/jk_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jk_counter_ctrl
// Description : Command-driven sequencer for a WIDTH-bit register built from
//               JK cells. Accepts hold/up/down/load commands with a step
//               count over valid/ready, drives the per-cell {j,k} excitation
//               each RUN cycle, and pulses done on completion.
//               Build option: JKCTRL_SATURATE_EN - up/down saturate at the
//               bounds instead of wrapping.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               cmd_valid/cmd_ready - command handshake
//               cmd_mode            - 00 hold, 01 up, 10 down, 11 load
//               cmd_count           - step count (ignored for load)
//               cmd_data            - load value
//               jk_bus              - {j_i,k_i} at bits [2i+1:2i]
//               q                   - register contents
//               busy, done, tc      - status (done is a 1-cycle pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module jk_counter_ctrl
    import jk_counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_mode,
    input  logic [CNT_W-1:0]   cmd_count,
    input  logic [WIDTH-1:0]   cmd_data,
    output logic [2*WIDTH-1:0] jk_bus,
    output logic [WIDTH-1:0]   q,
    output logic               busy,
    output logic               done,
    output logic               tc
);

    localparam logic [WIDTH-1:0] c_q_one   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_rem_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [1:0]         r_mode;
    logic [CNT_W-1:0]   r_rem;
    logic [WIDTH-1:0]   r_data;

    logic [WIDTH-1:0]   w_next;
    logic [2*WIDTH-1:0] w_jk;
    logic               w_all_ones;
    logic               w_zero;

    assign w_all_ones = &q;
    assign w_zero     = ~|q;

    // Value the register should hold after the current RUN step
    always_comb begin
        w_next = q;
        case (r_mode)
`ifdef JKCTRL_SATURATE_EN
            MODE_UP:   w_next = w_all_ones ? q : (q + c_q_one);
            MODE_DOWN: w_next = w_zero     ? q : (q - c_q_one);
`else
            MODE_UP:   w_next = q + c_q_one;
            MODE_DOWN: w_next = q - c_q_one;
`endif
            MODE_LOAD: w_next = r_data;
            default:   w_next = q;
        endcase
    end

    // Set only bits that must rise, reset only bits that must fall; the
    // toggle code can never appear because a bit cannot both rise and fall.
    always_comb begin
        w_jk = '0;
        if (r_state == S_RUN) begin
            for (int i = 0; i < WIDTH; i++) begin
                w_jk[2*i+1] = w_next[i] & ~q[i];
                w_jk[2*i]   = ~w_next[i] & q[i];
            end
        end
    end

    assign jk_bus = w_jk;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_cell u_cell (
                .clk (clk),
                .rst (rst),
                .j   (w_jk[2*gi+1]),
                .k   (w_jk[2*gi]),
                .q   (q[gi])
            );
        end
    endgenerate

    // Sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= MODE_HOLD;
            r_rem   <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_mode <= cmd_mode;
                        r_data <= cmd_data;
                        if (cmd_mode == MODE_LOAD) begin
                            r_rem   <= c_rem_one;
                            r_state <= S_RUN;
                        end else if (cmd_count == '0) begin
                            r_rem   <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_rem   <= cmd_count;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= r_rem - c_rem_one;
                    if (r_rem == c_rem_one) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign tc        = (r_state == S_RUN) &&
                       (((r_mode == MODE_UP)   && w_all_ones) ||
                        ((r_mode == MODE_DOWN) && w_zero));

endmodule : jk_counter_ctrl
`default_nettype wire

// File: tb/tb_jk_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_counter_ctrl
// Description : Self-checking bench for jk_counter_ctrl (WIDTH=4, CNT_W=8).
//               Expected register values come from modular integer
//               arithmetic on the command, not from the design's structure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_counter_ctrl;

    localparam int W    = 4;
    localparam int CW   = 8;
    localparam int MAXV = (1 << W) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_mode;
    logic [CW-1:0]   cmd_count;
    logic [W-1:0]    cmd_data;
    logic [2*W-1:0]  jk_bus;
    logic [W-1:0]    q;
    logic            busy;
    logic            done;
    logic            tc;

    int total = 0;
    int bad   = 0;
    int mq    = 0;   // model of register contents

    jk_counter_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .jk_bus    (jk_bus),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .tc        (tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next register value for one step of a command
    function automatic int model_next(input int m, input int cur, input int d);
        int v;
        v = cur;
        if (m == 1) begin
`ifdef JKCTRL_SATURATE_EN
            v = (cur == MAXV) ? cur : cur + 1;
`else
            v = (cur + 1) % (MAXV + 1);
`endif
        end else if (m == 2) begin
`ifdef JKCTRL_SATURATE_EN
            v = (cur == 0) ? cur : cur - 1;
`else
            v = (cur + MAXV) % (MAXV + 1);
`endif
        end else if (m == 3) begin
            v = d;
        end
        return v;
    endfunction

    // Excitation needed to move each cell from cur to nxt
    function automatic logic [2*W-1:0] model_jk(input int cur, input int nxt);
        logic [2*W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (((cur >> i) & 1) != ((nxt >> i) & 1))
                r[2*i +: 2] = (((nxt >> i) & 1) == 1) ? 2'b10 : 2'b01;
        end
        return r;
    endfunction

    // Issue one command and check every cycle until the handshake reopens
    task automatic run_cmd(input int m, input int cnt, input int d);
        int steps;
        int nv;
        logic exp_tc;
        cmd_mode  = m[1:0];
        cmd_count = cnt[CW-1:0];
        cmd_data  = d[W-1:0];
        cmd_valid = 1'b1;
        check("ready_before_accept", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_mode  = 2'($urandom);
        cmd_count = 8'($urandom);
        cmd_data  = 4'($urandom);
        steps = (m == 3) ? 1 : cnt;
        for (int s = 0; s < steps; s++) begin
            nv = model_next(m, mq, d);
            exp_tc = ((m == 1) && (mq == MAXV)) || ((m == 2) && (mq == 0));
            check("run_busy", busy, 1);
            check("run_ready", cmd_ready, 0);
            check("run_done", done, 0);
            check("run_jk", jk_bus, model_jk(mq, nv));
            check("run_tc", tc, exp_tc);
            tick();
            mq = nv;
            check("step_q", q, mq);
        end
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_jk", jk_bus, 0);
        check("done_ready", cmd_ready, 0);
        check("done_tc", tc, 0);
        check("done_q", q, mq);
        tick();
        check("idle_ready", cmd_ready, 1);
        check("idle_done", done, 0);
        check("idle_q", q, mq);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_mode  = 2'b01;
        cmd_count = 8'd5;
        cmd_data  = 4'hF;

        // Reset held for two cycles with a pending command
        tick();
        tick();
        check("rst_q", q, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tc", tc, 0);
        check("rst_jk", jk_bus, 0);
        cmd_valid = 1'b0;
        rst       = 1'b0;
        tick();
        check("post_rst_idle_busy", busy, 0);
        check("post_rst_q", q, 0);
        mq = 0;

        // Up by 3 from zero
        run_cmd(1, 3, 0);

        // Load 0101 then 1010 (second load drives 10011001)
        run_cmd(3, 0, 5);
        check("load_jk_pattern", model_jk(5, 10), 8'b10011001);
        run_cmd(3, 7, 10);

        // Wrap / saturate across all-ones
        run_cmd(3, 0, 14);
        run_cmd(1, 3, 0);

        // Down across zero
        run_cmd(3, 0, 1);
        run_cmd(2, 3, 0);

        // Zero-count down goes straight to DONE; hold for 4 cycles
        run_cmd(2, 0, 0);
        run_cmd(0, 4, 9);

        // Reset in the middle of an up-by-10
        cmd_mode  = 2'b01;
        cmd_count = 8'd10;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tick();
            mq = model_next(1, mq, 0);
            check("abort_step_q", q, mq);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mq  = 0;
        check("abort_q", q, 0);
        check("abort_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        for (int s = 0; s < 12; s++) begin
            check("abort_no_done", done, 0);
            tick();
        end
        run_cmd(1, 2, 0);

        // Randomized commands
        for (int n = 0; n < 30; n++) begin
            run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                    int'($urandom_range(0, MAXV)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_jk_counter_ctrl
`default_nettype wire

// File: doc/jk_counter_ctrl.md
Name: jk_counter_ctrl

Overview:
- Command-driven sequencer for a WIDTH-bit register built from JK flip-flop cells.
- Accepts a command (hold/up/down/load plus a step count) over a valid/ready handshake.
- Computes the per-bit {j,k} excitation each cycle to step the register, and pulses done when the command completes.
- Sits between a host FSM and the flip-flop bank; the bank is instantiated inside the block.

Parameters:
- WIDTH, 4: number of JK cells (register width).
- CNT_W, 8: width of the step-count field.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_mode  in  2  00 hold, 01 up, 10 down, 11 load.
- cmd_count  in  CNT_W  number of steps; ignored for load.
- cmd_data  in  WIDTH  load value.
- jk_bus  out  2*WIDTH  excitation per cell; bits [2i+1:2i] = {j_i,k_i}.
- q  out  WIDTH  register contents (cell outputs).
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- tc  out  1  terminal count: q==all-ones in up mode, or q==0 in down mode, while in RUN.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset:
  - State goes to IDLE and q clears to 0.
  - cmd_ready=1; busy=0, done=0, tc=0; jk_bus=0.
  - rst wins over every other event, including reset mid-command; the in-flight command is discarded with no done pulse.
- FSM: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1 and jk_bus=0.
  - A command is accepted on a cycle where cmd_valid && cmd_ready. The block latches mode, count (remaining) and data.
  - Next state after acceptance:
    - load: RUN with remaining=1.
    - count==0 in any non-load mode: DONE directly, with no step applied.
    - otherwise: RUN.
- RUN:
  - cmd_ready=0, busy=1.
  - Each cycle drives one step: next = q+1 (up), q-1 (down), q (hold), cmd_data (load).
  - Per bit, jk_bus drives j_i = next_i & ~q_i and k_i = ~next_i & q_i. The 11 (toggle) code is never driven.
  - q takes next at the following rising edge; remaining decrements by 1.
  - When remaining==1 the next state is DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle; jk_bus=0.
  - Returns to IDLE. cmd_ready is 0 in DONE, so back-to-back commands have a 1-cycle bubble.
- Latency: a command of N steps (N>=1) accepted at edge T applies steps at edges T+1..T+N; done is high in the cycle after edge T+N.
- Arithmetic is modulo 2^WIDTH unless overridden by the optional feature.
- cmd_valid while busy is ignored; the host must hold the command until it is accepted.
- jk_bus is combinational from state, q and latched mode/data.

Optional Feature:
- Macro: JKCTRL_SATURATE_EN.
- Defined: up stops at all-ones and down stops at 0. At the bound, next=q and jk_bus drives 00. Remaining steps still elapse and done fires on schedule.
- Undefined: wrap-around (all-ones+1 -> 0, 0-1 -> all-ones).
- tc behaviour is identical in both builds.

Decomposition:
- Shared package/header holds:
  - mode encodings: MODE_HOLD, MODE_UP, MODE_DOWN, MODE_LOAD.
  - state encodings: S_IDLE, S_RUN, S_DONE.
- One natural sub-module, jk_cell: a single JK flip-flop with synchronous active-high reset. It is instantiated WIDTH times via generate, with excitation 00 hold, 01 reset, 10 set, 11 toggle.
- Excitation logic and FSM stay in jk_counter_ctrl.

Test Plan:
- Reset: assert rst for 2 cycles with cmd_valid=1 -> q=0000, cmd_ready=1, done=0, jk_bus=0; no command accepted.
- Up count: mode=01, count=3 from q=0000 -> q=0001, 0010, 0011 on successive edges; done pulses 1 cycle after the third edge; cmd_ready returns the cycle after done.
- Load: load cmd_data=1010 from q=0101 -> jk_bus=10011001 for one RUN cycle; q=1010; done next cycle.
- Wrap/saturate: load 1110, then up count=3:
  - default build -> 1111, 0000, 0001, with tc=1 while q=1111.
  - JKCTRL_SATURATE_EN build -> 1111, 1111, 1111, with jk_bus=0 at the bound.
- Zero count and hold: down count=0 -> DONE the cycle after acceptance, q unchanged. Hold count=4 -> busy for 4 cycles, q unchanged, jk_bus=0.
- Reset mid-operation: up count=10, assert rst after 4 steps -> q=0000, state IDLE, no done pulse; a new command is accepted normally afterwards.
